// File: rtl/sfft_band_peak_finder.sv
// rtl/sfft_band_peak_finder.sv - per-band spectral peak picker fed by the SFFT pipeline
module sfft_band_peak_finder #(
   parameter int NFFT       = 256,
   parameter int DATA_W     = 32,
   parameter int BAND_SHIFT = 5,
   parameter int DROP_W     = 8,
   localparam int BIN_W     = $clog2(NFFT),
   localparam int HALF      = NFFT / 2,
   localparam int NUM_BANDS = HALF >> BAND_SHIFT,
   localparam int CNT_W     = $clog2(HALF),
   localparam int BAND_W    = CNT_W - BAND_SHIFT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NFFT*DATA_W-1:0]        SFFT_Out,
   input  logic                          OutputValid,
   output logic [NUM_BANDS*BIN_W-1:0]    peakBin,
   output logic [NUM_BANDS*DATA_W-1:0]   peakMag,
   output logic                          peaksValid,
   input  logic                          peaksAck,
   output logic                          busy,
   output logic [DROP_W-1:0]             droppedFrames
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    counter;
   logic [DATA_W-1:0]   buffer   [HALF];
   logic [DATA_W-1:0]   acc_mag  [NUM_BANDS];
   logic [BIN_W-1:0]    acc_bin  [NUM_BANDS];
   logic [DATA_W-1:0]   hold_mag [NUM_BANDS];
   logic [BIN_W-1:0]    hold_bin [NUM_BANDS];
   logic [BAND_W-1:0]   cur_band;
   logic [DATA_W-1:0]   cur_val;
   logic [DATA_W-1:0]   cur_mag;
   logic                upd;
   logic                capture;
   logic                drop;
   logic                scan_last;
   logic                unused_upper;

   // The mirrored upper half of the spectrum is never examined.
   assign unused_upper = ^SFFT_Out[NFFT*DATA_W-1:HALF*DATA_W];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic; an ack coinciding with a new frame goes straight back to SCAN
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (OutputValid) next_state = S_SCAN;
         S_SCAN:  if (counter == CNT_W'(HALF - 1)) next_state = S_HOLD;
         S_HOLD:  if (peaksAck) next_state = OutputValid ? S_SCAN : S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output and control decode from the current state
   always_comb begin
      busy       = (state != S_IDLE);
      peaksValid = (state == S_HOLD);
      capture    = OutputValid && ((state == S_IDLE) || ((state == S_HOLD) && peaksAck));
      drop       = OutputValid && !capture && (state != S_IDLE);
      scan_last  = (state == S_SCAN) && (counter == CNT_W'(HALF - 1));
   end

   // Magnitude of the bin under scan: DC forced to 0, most-negative saturates
   always_comb begin
      cur_band = counter[CNT_W-1:BAND_SHIFT];
      cur_val  = buffer[counter];
      if (counter == '0)             cur_mag = '0;
      else if (cur_val == MOST_NEG)  cur_mag = MOST_POS;
      else if (cur_val[DATA_W-1])    cur_mag = -cur_val;
      else                           cur_mag = cur_val;
      upd = (state == S_SCAN) && (cur_mag > acc_mag[cur_band]);
   end

   // Frame buffer: lower half-spectrum latched in the capture cycle
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < HALF; i++) buffer[i] <= SFFT_Out[i*DATA_W +: DATA_W];
      end
   end

   // Scan counter, band accumulators, held results and drop counter
   always_ff @(posedge clk) begin
      if (reset) begin
         counter       <= '0;
         droppedFrames <= '0;
         for (int b = 0; b < NUM_BANDS; b++) begin
            acc_mag[b]  <= '0;
            acc_bin[b]  <= '0;
            hold_mag[b] <= '0;
            hold_bin[b] <= '0;
         end
      end else begin
         if (capture) begin
            counter <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
               acc_mag[b] <= '0;
               acc_bin[b] <= BIN_W'(b << BAND_SHIFT);
            end
         end else if (state == S_SCAN) begin
            counter <= counter + 1'b1;
            if (upd) begin
               acc_mag[cur_band] <= cur_mag;
               acc_bin[cur_band] <= BIN_W'(counter);
            end
            // Publish including the update for the final bin of this scan
            if (scan_last) begin
               for (int b = 0; b < NUM_BANDS; b++) begin
                  if (upd && (cur_band == BAND_W'(b))) begin
                     hold_mag[b] <= cur_mag;
                     hold_bin[b] <= BIN_W'(counter);
                  end else begin
                     hold_mag[b] <= acc_mag[b];
                     hold_bin[b] <= acc_bin[b];
                  end
               end
            end
         end
         if (drop && (droppedFrames != {DROP_W{1'b1}})) droppedFrames <= droppedFrames + 1'b1;
      end
   end

   // Flatten held results onto the output buses
   always_comb begin
      for (int b = 0; b < NUM_BANDS; b++) begin
         peakBin[b*BIN_W +: BIN_W]   = hold_bin[b];
         peakMag[b*DATA_W +: DATA_W] = hold_mag[b];
      end
   end

endmodule

// File: tb/tb_sfft_band_peak_finder.sv
// tb/tb_sfft_band_peak_finder.sv - self-checking bench for sfft_band_peak_finder
module tb_sfft_band_peak_finder;

   localparam int NFFT  = 256;
   localparam int DW    = 32;
   localparam int BW    = 8;
   localparam int NB    = 4;
   localparam int BANDW = 32;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NFFT*DW-1:0]   sfft_out = '0;
   logic                 output_valid = 1'b0;
   logic                 peaks_ack = 1'b0;
   logic [NB*BW-1:0]     peak_bin;
   logic [NB*DW-1:0]     peak_mag;
   logic                 peaks_valid;
   logic                 busy;
   logic [7:0]           dropped;

   logic [DW-1:0]        frame   [NFFT];
   logic [BW-1:0]        exp_bin [NB];
   logic [DW-1:0]        exp_mag [NB];
   int                   checks = 0;
   int                   passed = 0;
   int                   lat;

   sfft_band_peak_finder dut (
      .clk           (clk),
      .reset         (reset),
      .SFFT_Out      (sfft_out),
      .OutputValid   (output_valid),
      .peakBin       (peak_bin),
      .peakMag       (peak_mag),
      .peaksValid    (peaks_valid),
      .peaksAck      (peaks_ack),
      .busy          (busy),
      .droppedFrames (dropped)
   );

   always #5 clk = ~clk;

   task automatic load_frame();
      for (int i = 0; i < NFFT; i++) sfft_out[i*DW +: DW] = frame[i];
   endtask

   task automatic clear_frame();
      for (int i = 0; i < NFFT; i++) frame[i] = '0;
   endtask

   task automatic random_frame();
      for (int i = 0; i < NFFT; i++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r < 6)       frame[i] = '0;
         else if (r < 12) frame[i] = 32'($signed($urandom_range(0, 30)) - 15);
         else if (r < 15) frame[i] = $urandom;
         else             frame[i] = 32'h8000_0000;
      end
   endtask

   // Reference: strongest |value| per band, DC ignored, first occurrence wins
   task automatic model();
      for (int b = 0; b < NB; b++) begin
         longint best_m;
         int     best_i;
         best_m = 0;
         best_i = b * BANDW;
         for (int i = b * BANDW; i < (b + 1) * BANDW; i++) begin
            longint s;
            longint m;
            s = longint'($signed(frame[i]));
            m = (s < 0) ? -s : s;
            if (m > 64'sd2147483647) m = 64'sd2147483647;
            if (i == 0) m = 0;
            if (m > best_m) begin
               best_m = m;
               best_i = i;
            end
         end
         exp_bin[b] = BW'(best_i);
         exp_mag[b] = DW'(best_m);
      end
   endtask

   task automatic pulse(input bit ov, input bit ack);
      @(negedge clk);
      output_valid = ov;
      peaks_ack = ack;
      @(posedge clk);
      #1;
      output_valid = 1'b0;
      peaks_ack = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!peaks_valid && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (20) @(posedge clk);
      #1;
      checks++; if (peaks_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", peaks_valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
      checks++; if (dropped !== 8'd0) $display("FAIL reset_dropped got %0d want 0", dropped); else passed++;
      checks++; if (peak_bin !== '0) $display("FAIL reset_bin got %h want 0", peak_bin); else passed++;
      checks++; if (peak_mag !== '0) $display("FAIL reset_mag got %h want 0", peak_mag); else passed++;
   endtask

   task automatic test_directed();
      clear_frame();
      frame[5]   = 32'd1000;
      frame[40]  = -32'd3000;
      frame[70]  = 32'd200;
      frame[127] = 32'd7;
      frame[200] = 32'd99999;
      frame[128] = -32'd88888;
      exp_bin = '{8'd5, 8'd40, 8'd70, 8'd127};
      exp_mag = '{32'd1000, 32'd3000, 32'd200, 32'd7};
      load_frame();
      pulse(1'b1, 1'b0);
      checks++; if (busy !== 1'b1) $display("FAIL dir_busy got %0b want 1", busy); else passed++;
      wait_valid(lat);
      checks++; if (lat != 128) $display("FAIL dir_latency got %0d want 128", lat); else passed++;
      for (int b = 0; b < NB; b++) begin
         checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL dir_bin%0d got %0d want %0d", b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
         checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL dir_mag%0d got %0d want %0d", b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
      end
      pulse(1'b0, 1'b1);
      checks++; if (peaks_valid !== 1'b0 || busy !== 1'b0) $display("FAIL dir_ack valid=%0b busy=%0b want 0 0", peaks_valid, busy); else passed++;
   endtask

   task automatic test_ties();
      clear_frame();
      frame[33] = -32'd500;
      frame[60] = -32'd500;
      frame[0]  = 32'd9999;
      exp_bin = '{8'd0, 8'd33, 8'd64, 8'd96};
      exp_mag = '{32'd0, 32'd500, 32'd0, 32'd0};
      load_frame();
      pulse(1'b1, 1'b0);
      wait_valid(lat);
      for (int b = 0; b < NB; b++) begin
         checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL tie_bin%0d got %0d want %0d", b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
         checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL tie_mag%0d got %0d want %0d", b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
      end
      pulse(1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      clear_frame();
      frame[100] = 32'h8000_0000;
      frame[101] = 32'h8000_0001;
      frame[10]  = 32'h7FFF_FFFF;
      load_frame();
      pulse(1'b1, 1'b0);
      wait_valid(lat);
      checks++; if (peak_bin[3*BW +: BW] !== 8'd100) $display("FAIL sat_bin got %0d want 100", peak_bin[3*BW +: BW]); else passed++;
      checks++; if (peak_mag[3*DW +: DW] !== 32'h7FFF_FFFF) $display("FAIL sat_mag got %h want 7fffffff", peak_mag[3*DW +: DW]); else passed++;
      checks++; if (peak_mag[0*DW +: DW] !== 32'h7FFF_FFFF) $display("FAIL sat_pos got %h want 7fffffff", peak_mag[0*DW +: DW]); else passed++;
      pulse(1'b0, 1'b1);
   endtask

   task automatic test_drops();
      random_frame();
      model();
      load_frame();
      pulse(1'b1, 1'b0);
      repeat (10) @(posedge clk);
      random_frame();
      load_frame();
      pulse(1'b1, 1'b0);
      wait_valid(lat);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      checks++; if (dropped !== 8'd3) $display("FAIL drop_count got %0d want 3", dropped); else passed++;
      checks++; if (peaks_valid !== 1'b1) $display("FAIL drop_hold got %0b want 1", peaks_valid); else passed++;
      for (int b = 0; b < NB; b++) begin
         checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL drop_bin%0d got %0d want %0d", b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
         checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL drop_mag%0d got %0d want %0d", b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
      end
      random_frame();
      model();
      load_frame();
      pulse(1'b1, 1'b1);
      checks++; if (busy !== 1'b1 || peaks_valid !== 1'b0) $display("FAIL ackov_state busy=%0b valid=%0b want 1 0", busy, peaks_valid); else passed++;
      checks++; if (dropped !== 8'd3) $display("FAIL ackov_drop got %0d want 3", dropped); else passed++;
      wait_valid(lat);
      checks++; if (lat != 128) $display("FAIL ackov_latency got %0d want 128", lat); else passed++;
      for (int b = 0; b < NB; b++) begin
         checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL ackov_bin%0d got %0d want %0d", b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
         checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL ackov_mag%0d got %0d want %0d", b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
      end
      pulse(1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_scan();
      random_frame();
      load_frame();
      pulse(1'b1, 1'b0);
      repeat (50) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || peaks_valid !== 1'b0) $display("FAIL mid_reset busy=%0b valid=%0b want 0 0", busy, peaks_valid); else passed++;
      checks++; if (dropped !== 8'd0) $display("FAIL mid_reset_drop got %0d want 0", dropped); else passed++;
      checks++; if (peak_mag !== '0) $display("FAIL mid_reset_mag got %h want 0", peak_mag); else passed++;
      random_frame();
      model();
      load_frame();
      pulse(1'b1, 1'b0);
      wait_valid(lat);
      checks++; if (lat != 128) $display("FAIL post_reset_latency got %0d want 128", lat); else passed++;
      for (int b = 0; b < NB; b++) begin
         checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL post_reset_bin%0d got %0d want %0d", b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
         checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL post_reset_mag%0d got %0d want %0d", b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         random_frame();
         model();
         load_frame();
         pulse(1'b1, 1'b1);
         checks++; if (busy !== 1'b1 || peaks_valid !== 1'b0) $display("FAIL b2b%0d_state busy=%0b valid=%0b want 1 0", k, busy, peaks_valid); else passed++;
         wait_valid(lat);
         checks++; if (lat != 128) $display("FAIL b2b%0d_latency got %0d want 128", k, lat); else passed++;
         for (int b = 0; b < NB; b++) begin
            checks++; if (peak_bin[b*BW +: BW] !== exp_bin[b]) $display("FAIL b2b%0d_bin%0d got %0d want %0d", k, b, peak_bin[b*BW +: BW], exp_bin[b]); else passed++;
            checks++; if (peak_mag[b*DW +: DW] !== exp_mag[b]) $display("FAIL b2b%0d_mag%0d got %0d want %0d", k, b, peak_mag[b*DW +: DW], exp_mag[b]); else passed++;
         end
      end
      checks++; if (dropped !== 8'd0) $display("FAIL b2b_drop got %0d want 0", dropped); else passed++;
      pulse(1'b0, 1'b1);
      checks++; if (busy !== 1'b0) $display("FAIL b2b_final_busy got %0b want 0", busy); else passed++;
   endtask

   initial begin
      clear_frame();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_directed();
      test_ties();
      test_saturation();
      test_drops();
      test_reset_mid_scan();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
